// File: rtl/digit_serial_mult.sv
// Digit-serial P x P multiplier with an internal column scheduler and valid/ready on both sides.
// Two's-complement support is compiled in only when SEQ_MULT_SIGNED_EN is defined.
module digit_serial_mult #(
  parameter int P = 2,
  parameter int MAX_WIDTH = 16,
  localparam int ND = MAX_WIDTH / P
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_WIDTH-1:0]  a,
  input  logic [MAX_WIDTH-1:0]  b,
  input  logic [$clog2(ND):0]   num_digits,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [P-1:0]          out_digit,
  output logic                  out_last,
  output logic                  busy
);
  localparam int CW = $clog2(ND) + 1;
  localparam int AW = 2 * P + $clog2(ND) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH} state_t;
  state_t state, state_nxt;

  logic [MAX_WIDTH-1:0] a_q, b_q, mask, a_m, b_m, a_mag, b_mag;
  logic [CW-1:0]        n_q, i_q, n_eff, lo_next;
  logic [CW:0]          k_q, k_inc, two_n, hi, j;
  logic [AW-1:0]        acc_q, sum;
  logic [P-1:0]         da, db, raw, dig;
  logic [2*P-1:0]       term;
  logic                 last_col, col_end, emit, stall;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 neg_q, carry_q, neg_in, sign_a, sign_b, neg_co;
  logic [P-1:0]         neg_d;
`else
  logic                 unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  // operand conditioning at accept: clamp N, mask unused bits, take magnitudes
  always_comb begin
    n_eff = num_digits;
    if (num_digits == '0 || num_digits > CW'(ND)) n_eff = CW'(ND);
    mask  = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - int'(n_eff) * P);
    a_m   = a & mask;
    b_m   = b & mask;
    a_mag = a_m;
    b_mag = b_m;
`ifdef SEQ_MULT_SIGNED_EN
    sign_a = signed_mode && (|(a_m & ~(mask >> 1)));
    sign_b = signed_mode && (|(b_m & ~(mask >> 1)));
    if (sign_a) a_mag = (~a_m + MAX_WIDTH'(1)) & mask;
    if (sign_b) b_mag = (~b_m + MAX_WIDTH'(1)) & mask;
    neg_in = sign_a ^ sign_b;
`endif
  end

  always_comb begin
    two_n    = {n_q, 1'b0};
    last_col = (k_q == two_n - (CW+1)'(1));
    hi       = (k_q < {1'b0, n_q}) ? k_q : {1'b0, n_q} - (CW+1)'(1);
    col_end  = ({1'b0, i_q} == hi);
    k_inc    = k_q + (CW+1)'(1);
    lo_next  = (k_inc >= {1'b0, n_q}) ? CW'(k_inc - {1'b0, n_q} + (CW+1)'(1)) : '0;
    j        = k_q - {1'b0, i_q};
    da       = P'(a_q >> (int'(i_q) * P));
    db       = P'(b_q >> (int'(j) * P));
    term     = {{P{1'b0}}, da} * {{P{1'b0}}, db};
    sum      = acc_q + AW'(term);
    raw      = last_col ? acc_q[P-1:0] : sum[P-1:0];
    emit     = (state == COMPUTE) && (last_col || col_end);
    stall    = emit && out_valid && !out_ready;
`ifdef SEQ_MULT_SIGNED_EN
    {neg_co, neg_d} = {1'b0, ~raw} + {{P{1'b0}}, carry_q};
    dig = neg_q ? neg_d : raw;
`else
    dig = raw;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = COMPUTE;
      COMPUTE: if (last_col && !stall) state_nxt = FLUSH;
      FLUSH:   if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; n_q <= '0; i_q <= '0; k_q <= '0; acc_q <= '0;
      out_valid <= 1'b0; out_digit <= '0; out_last <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q <= 1'b0; carry_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= a_mag; b_q <= b_mag; n_q <= n_eff;
        i_q <= '0; k_q <= '0; acc_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_q <= neg_in; carry_q <= 1'b1;
`endif
      end
      if (state == COMPUTE && !stall && !last_col) begin
        if (col_end) begin
          acc_q <= sum >> P;
          k_q   <= k_inc;
          i_q   <= lo_next;
        end else begin
          acc_q <= sum;
          i_q   <= i_q + CW'(1);
        end
      end
      // single-entry output register; emit may coincide with drain
      if (emit && !stall) begin
        out_valid <= 1'b1;
        out_digit <= dig;
        out_last  <= last_col;
`ifdef SEQ_MULT_SIGNED_EN
        carry_q   <= neg_co;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_digit_serial_mult.sv
// Bench for digit_serial_mult: directed cases plus random operands with random backpressure,
// checked against an arithmetic product model (signed mode follows SEQ_MULT_SIGNED_EN).
module tb_digit_serial_mult;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  num_digits = '0;
  logic        signed_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_digit;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int first_cyc, last_cyc;

  digit_serial_mult #(.P(2), .MAX_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .num_digits(num_digits), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected 2N-digit product from plain integer arithmetic
  function automatic logic [63:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                        input logic [3:0] tn, input logic ts, output int n);
    longint am, bm, prod;
    int w;
    n  = (tn == 0 || tn > 8) ? 8 : int'(tn);
    w  = 2 * n;
    am = longint'(ta) & ((longint'(1) << w) - 1);
    bm = longint'(tb) & ((longint'(1) << w) - 1);
`ifdef SEQ_MULT_SIGNED_EN
    if (ts && am[w-1]) am = am - (longint'(1) << w);
    if (ts && bm[w-1]) bm = bm - (longint'(1) << w);
`else
    if (ts) n = n;
`endif
    prod = am * bm;
    return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [3:0] tn, input logic ts, input int rdy);
    logic [63:0] exp_p;
    int n, cyc, got;
    logic prev_stall;
    logic [1:0] prev_d;
    logic prev_l;
    exp_p = model(ta, tb, tn, ts, n);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb; num_digits = tn; signed_mode = ts;
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    num_digits = 4'($urandom); signed_mode = 1'($urandom);
    check({tag, ":busy_compute"}, 64'(busy), 64'd1);
    check({tag, ":in_ready_compute"}, 64'(in_ready), 64'd0);
    cyc = 1; got = 0; first_cyc = -1; last_cyc = -1;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (got < 2 * n && cyc < 3000) begin
      out_ready = ($urandom_range(99) < rdy);
      if (prev_stall) begin
        check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, ":hold_digit"}, 64'(out_digit), 64'(prev_d));
        check({tag, ":hold_last"}, 64'(out_last), 64'(prev_l));
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (out_ready) begin
          check({tag, ":digit"}, 64'(out_digit), (exp_p >> (2 * got)) & 64'd3);
          check({tag, ":last_flag"}, 64'(out_last), 64'(got == 2 * n - 1));
          if (got == 2 * n - 1) last_cyc = cyc;
          got++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_digit;
      prev_l = out_last;
      @(negedge clk);
      cyc++;
    end
    check({tag, ":digit_count"}, 64'(got), 64'(2 * n));
    check({tag, ":idle_after"}, 64'(in_ready), 64'd1);
    check({tag, ":busy_after"}, 64'(busy), 64'd0);
    check({tag, ":valid_after"}, 64'(out_valid), 64'd0);
    if (rdy >= 100) begin
      check({tag, ":first_valid_cyc"}, 64'(first_cyc), 64'd2);
      check({tag, ":last_valid_cyc"}, 64'(last_cyc), 64'(n * n + 2));
    end
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst:in_ready", 64'(in_ready), 64'd1);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:out_digit", 64'(out_digit), 64'd0);
    check("rst:out_last", 64'(out_last), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    rst = 1'b0;

    run_op("n1_3x3", 16'h0003, 16'h0003, 4'd1, 1'b0, 100);
    run_op("n8_ffff_sq", 16'hFFFF, 16'hFFFF, 4'd8, 1'b0, 100);
    run_op("s_8000_sq", 16'h8000, 16'h8000, 4'd8, 1'b1, 100);
    run_op("s_ffff_x5", 16'hFFFF, 16'h0005, 4'd8, 1'b1, 100);
    run_op("u_ffff_x5", 16'hFFFF, 16'h0005, 4'd8, 1'b0, 100);
    run_op("nd0", 16'h1234, 16'hBEEF, 4'd0, 1'b0, 100);
    run_op("nd9", 16'hA5C3, 16'h7E01, 4'd9, 1'b0, 100);
    run_op("n2_mask", 16'hFF03, 16'h0002, 4'd2, 1'b0, 100);
    run_op("s_n3", 16'hFF2A, 16'h0017, 4'd3, 1'b1, 100);

    // reset in the middle of a product
    @(negedge clk);
    in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; num_digits = 4'd8; signed_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst:in_ready", 64'(in_ready), 64'd1);
    check("midrst:out_valid", 64'(out_valid), 64'd0);
    check("midrst:out_digit", 64'(out_digit), 64'd0);
    check("midrst:out_last", 64'(out_last), 64'd0);
    check("midrst:busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("postrst:out_valid", 64'(out_valid), 64'd0);
      check("postrst:busy", 64'(busy), 64'd0);
    end
    run_op("after_rst", 16'h1357, 16'h2468, 4'd8, 1'b0, 100);

    for (int t = 0; t < 200; t++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
